// File: rtl/bus_ctrl_2m2s.sv
// rtl/bus_ctrl_2m2s.sv - two-master/two-slave bus arbiter, steering, decode and read return
// Optional BUS_RR_EN: contested grants from IDLE alternate using a last-grant register.
module bus_ctrl_2m2s #(
    parameter int ADDR_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [31:0]       m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [31:0]       m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_wr,
    output logic [31:0]       s_din,
    output logic              s0_sel,
    output logic              s1_sel,
    input  logic [31:0]       s0_dout,
    input  logic [31:0]       s1_dout,
    output logic [31:0]       m_din
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    state_t      r_state;
    logic [7:0]  r_hold_cnt;
    logic [1:0]  r_rd_sel_q;
    logic        w_own_req;
    logic        w_idle_pick0;

`ifdef BUS_RR_EN
    // 0 = M0 granted last, 1 = M1 granted last
    logic        r_last_gnt;
    assign w_idle_pick0 = m0_req && (!m1_req || r_last_gnt);
`else
    assign w_idle_pick0 = m0_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
`ifdef BUS_RR_EN
            r_last_gnt <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_idle_pick0) begin
                        r_state <= GRANT0;
`ifdef BUS_RR_EN
                        r_last_gnt <= 1'b0;
`endif
                    end else if (m1_req) begin
                        r_state <= GRANT1;
`ifdef BUS_RR_EN
                        r_last_gnt <= 1'b1;
`endif
                    end
                end
                GRANT0: begin
                    if (!m0_req || (m1_req && r_hold_cnt == HOLD_MAX)) begin
                        r_hold_cnt <= '0;
                        if (m1_req) begin
                            r_state <= GRANT1;
`ifdef BUS_RR_EN
                            r_last_gnt <= 1'b1;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                GRANT1: begin
                    if (!m1_req || (m0_req && r_hold_cnt == HOLD_MAX)) begin
                        r_hold_cnt <= '0;
                        if (m0_req) begin
                            r_state <= GRANT0;
`ifdef BUS_RR_EN
                            r_last_gnt <= 1'b0;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign m0_grant = (r_state == GRANT0);
    assign m1_grant = (r_state == GRANT1);

    always_comb begin
        s_address = '0;
        s_wr      = 1'b0;
        s_din     = '0;
        w_own_req = 1'b0;
        case (r_state)
            GRANT0: begin
                s_address = m0_address;
                s_wr      = m0_wr & m0_req;
                s_din     = m0_dout;
                w_own_req = m0_req;
            end
            GRANT1: begin
                s_address = m1_address;
                s_wr      = m1_wr & m1_req;
                s_din     = m1_dout;
                w_own_req = m1_req;
            end
            default: begin
                s_address = '0;
            end
        endcase
    end

    // Addresses at 0x40 and above map to no slave, so writes there are dropped
    assign s0_sel = w_own_req && (32'(s_address) < 32'h20);
    assign s1_sel = w_own_req && (32'(s_address) >= 32'h20) && (32'(s_address) < 32'h40);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sel_q <= 2'b00;
        end else begin
            r_rd_sel_q <= {s1_sel, s0_sel};
        end
    end

    always_comb begin
        m_din = '0;
        case (r_rd_sel_q)
            2'b01:   m_din = s0_dout;
            2'b10:   m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_ctrl_2m2s.sv
// tb/tb_bus_ctrl_2m2s.sv - randomized self-checking bench for bus_ctrl_2m2s with ownership model
module tb_bus_ctrl_2m2s;

    localparam int ADDR_W   = 8;
    localparam int MAX_HOLD = 16;
`ifdef BUS_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [31:0]       m0_dout, m1_dout;
    logic              m0_grant, m1_grant;
    logic [ADDR_W-1:0] s_address;
    logic              s_wr;
    logic [31:0]       s_din;
    logic              s0_sel, s1_sel;
    logic [31:0]       s0_dout, s1_dout;
    logic [31:0]       m_din;

    bus_ctrl_2m2s #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant),
        .s_address(s_address), .s_wr(s_wr), .s_din(s_din),
        .s0_sel(s0_sel), .s1_sel(s1_sel),
        .s0_dout(s0_dout), .s1_dout(s1_dout), .m_din(m_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 M0, 2 M1), how long it has held, who won last
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [31:0]       d;
        logic [1:0]        sel;
    } bus_t;

    int         mo_owner, mo_run, mo_last, mo_next;
    logic [1:0] mo_prev_sel;
    bus_t       mdl_b, cmp_b;
    logic [31:0] exp_din;

    function automatic logic [1:0] decode(input logic [ADDR_W-1:0] a);
        if (int'(a) < 32) return 2'b01;
        if (int'(a) < 64) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bus_t model_bus();
        bus_t b;
        b = '0;
        if (mo_owner == 1) begin
            b.a = m0_address; b.w = m0_wr & m0_req; b.d = m0_dout;
            if (m0_req) b.sel = decode(m0_address);
        end else if (mo_owner == 2) begin
            b.a = m1_address; b.w = m1_wr & m1_req; b.d = m1_dout;
            if (m1_req) b.sel = decode(m1_address);
        end
        return b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mo_owner = 0; mo_run = 0; mo_last = 2; mo_prev_sel = 2'b00;
        end else begin
            mdl_b = model_bus();
            mo_prev_sel = mdl_b.sel;
            if (mo_owner == 0) begin
                if (m0_req && m1_req) mo_next = (RR && mo_last == 1) ? 2 : 1;
                else if (m0_req)      mo_next = 1;
                else if (m1_req)      mo_next = 2;
                else                  mo_next = 0;
            end else begin
                logic own, oth;
                own = (mo_owner == 1) ? m0_req : m1_req;
                oth = (mo_owner == 1) ? m1_req : m0_req;
                if (!own)                            mo_next = oth ? 3 - mo_owner : 0;
                else if (oth && mo_run >= MAX_HOLD)  mo_next = 3 - mo_owner;
                else                                 mo_next = mo_owner;
            end
            if (mo_next != mo_owner) begin
                mo_run = (mo_next != 0) ? 1 : 0;
                if (mo_next != 0) mo_last = mo_next;
            end else if (mo_next != 0) begin
                mo_run++;
            end
            mo_owner = mo_next;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            cmp_b = model_bus();
            exp_din = (mo_prev_sel == 2'b01) ? s0_dout : (mo_prev_sel == 2'b10) ? s1_dout : 32'd0;
            chk("m0_grant", 32'(m0_grant), 32'(mo_owner == 1));
            chk("m1_grant", 32'(m1_grant), 32'(mo_owner == 2));
            chk("s_address", 32'(s_address), 32'(cmp_b.a));
            chk("s_wr", 32'(s_wr), 32'(cmp_b.w));
            chk("s_din", s_din, cmp_b.d);
            chk("sel", 32'({s1_sel, s0_sel}), 32'(cmp_b.sel));
            chk("m_din", m_din, exp_din);
        end
    end

    initial begin
        int bad, cnt, mode;
        m0_req = 0; m0_wr = 0; m0_address = '0; m0_dout = '0;
        m1_req = 0; m1_wr = 0; m1_address = '0; m1_dout = '0;
        s0_dout = 32'hAAAA5555; s1_dout = 32'h12345678;
        repeat (2) @(negedge clk);
        chk("rst_m0_grant", 32'(m0_grant), 32'd0);
        chk("rst_m1_grant", 32'(m1_grant), 32'd0);
        chk("rst_s_wr", 32'(s_wr), 32'd0);
        chk("rst_m_din", m_din, 32'd0);
        chk("rst_sel", 32'({s1_sel, s0_sel}), 32'd0);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        m0_req = 1; m0_wr = 1; m0_address = 8'h05; m0_dout = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_m0_grant", 32'(m0_grant), 32'd1);
        chk("t1_s0_sel", 32'(s0_sel), 32'd1);
        chk("t1_s1_sel", 32'(s1_sel), 32'd0);
        chk("t1_s_wr", 32'(s_wr), 32'd1);
        chk("t1_s_din", s_din, 32'hDEADBEEF);

        m0_req = 0; m0_wr = 0; m1_req = 1; m1_wr = 0; m1_address = 8'h24;
        @(negedge clk);
        chk("t2_m1_grant", 32'(m1_grant), 32'd1);
        chk("t2_s1_sel", 32'(s1_sel), 32'd1);
        @(negedge clk);
        chk("t2_m_din", m_din, 32'h12345678);

        m1_req = 0;
        @(negedge clk);
        chk("t3_idle", 32'({m1_grant, m0_grant}), 32'd0);
        m0_req = 1; m1_req = 1; m0_address = 8'h10; m1_address = 8'h30;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (m0_grant !== (((i / MAX_HOLD) % 2) == 0)) bad++;
            if (m1_grant !== (((i / MAX_HOLD) % 2) == 1)) bad++;
        end
        chk("t3_alternate_16", 32'(bad), 32'd0);

        m1_req = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m0_grant === 1'b1 && m1_grant === 1'b0) cnt++;
        end
        chk("t4_hold_40", 32'(cnt), 32'd40);
        m1_req = 1;
        @(negedge clk);
        chk("t4_saturated_release", 32'(m1_grant), 32'd1);

        m1_req = 0; m0_req = 1; m0_wr = 1; m0_address = 8'h80; m0_dout = 32'h0BAD0BAD;
        @(negedge clk);
        chk("t5_m0_grant", 32'(m0_grant), 32'd1);
        chk("t5_no_sel", 32'({s1_sel, s0_sel}), 32'd0);
        @(negedge clk);
        chk("t5_m_din_zero", m_din, 32'd0);

        m0_req = 0; m0_wr = 0; m1_req = 1; m1_wr = 1; m1_address = 8'h10;
        @(negedge clk);
        chk("t6_m1_grant", 32'(m1_grant), 32'd1);
        chk("t6_s_wr", 32'(s_wr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_grant", 32'({m1_grant, m0_grant}), 32'd0);
        chk("t6_async_s_wr", 32'(s_wr), 32'd0);
        chk("t6_async_m_din", m_din, 32'd0);
        m1_req = 0; m1_wr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_after", 32'({m1_grant, m0_grant}), 32'd0);

        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("t7_first_contest_m0", 32'(m0_grant), 32'd1);
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("t7_second_contest", 32'(m1_grant), 32'(RR));

        mode = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (n % 100 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            if (mode == 0) begin
                m0_req = ($urandom_range(0, 3) != 0);
                m1_req = ($urandom_range(0, 3) != 0);
            end else if (mode == 1) begin
                if ($urandom_range(0, 39) == 0) m0_req = ~m0_req;
                if ($urandom_range(0, 39) == 0) m1_req = ~m1_req;
                if ($urandom_range(0, 9) == 0) begin m0_req = 1; m1_req = 1; end
            end else begin
                m0_req = $urandom_range(0, 1);
                m1_req = ($urandom_range(0, 7) == 0);
            end
            m0_wr = $urandom_range(0, 1);
            m1_wr = $urandom_range(0, 1);
            m0_address = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 8'h4F));
            m1_address = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 8'h4F));
            m0_dout = $urandom; m1_dout = $urandom;
            s0_dout = $urandom; s1_dout = $urandom;
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
